// File: rtl/frame_sequencer.sv
// Per-frame sequencer: on each frame_tick it erases the framebuffer, starts the entity draw
// pass, then the game-state update, with a bounded wait on each done handshake.
module frame_sequencer #(
    parameter int SCREEN_W = 160,
    parameter int SCREEN_H = 120,
    parameter int TIMEOUT  = 65535
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        frame_tick,
    input  logic        pass_done,
    input  logic        update_done,
    output logic [7:0]  clr_x,
    output logic [6:0]  clr_y,
    output logic        clr_we,
    output logic        draw_go,
    output logic        update_go,
    output logic        busy,
    output logic [2:0]  state,
    output logic [15:0] frame_count,
    output logic        overrun,
    output logic        timeout_err
);

    // state       | meaning
    // S_IDLE      | waiting for frame_tick
    // S_CLEAR     | erasing one pixel per cycle
    // S_DRAW      | one-cycle draw_go pulse
    // S_DRAW_WAIT | waiting for pass_done (bounded)
    // S_UPDATE    | one-cycle update_go pulse
    // S_UPD_WAIT  | waiting for update_done (bounded)
    localparam logic [2:0] S_IDLE      = 3'd0;
    localparam logic [2:0] S_CLEAR     = 3'd1;
    localparam logic [2:0] S_DRAW      = 3'd2;
    localparam logic [2:0] S_DRAW_WAIT = 3'd3;
    localparam logic [2:0] S_UPDATE    = 3'd4;
    localparam logic [2:0] S_UPD_WAIT  = 3'd5;

    localparam logic [7:0]  X_LAST  = 8'(SCREEN_W - 1);
    localparam logic [6:0]  Y_LAST  = 7'(SCREEN_H - 1);
    localparam logic [15:0] WAIT_TO = 16'(TIMEOUT);

    logic [2:0]  state_q, state_d;
    logic [7:0]  clr_x_q, clr_x_d;
    logic [6:0]  clr_y_q, clr_y_d;
    logic        clr_we_q, clr_we_d;
    logic        draw_go_q, draw_go_d;
    logic        update_go_q, update_go_d;
    logic        busy_q, busy_d;
    logic [15:0] frame_count_q, frame_count_d;
    logic        overrun_q, overrun_d;
    logic        timeout_err_q, timeout_err_d;
    logic [15:0] wait_q, wait_d;

    logic clear_last;
    logic wait_expired;

    assign clear_last   = (clr_x_q == X_LAST) && (clr_y_q == Y_LAST);
    assign wait_expired = (wait_q == WAIT_TO);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:      if (frame_tick) state_d = S_CLEAR;
            S_CLEAR:     if (clear_last) state_d = S_DRAW;
            S_DRAW:      state_d = S_DRAW_WAIT;
            S_DRAW_WAIT: begin
                if (pass_done)         state_d = S_UPDATE;
                else if (wait_expired) state_d = S_IDLE;
            end
            S_UPDATE:    state_d = S_UPD_WAIT;
            S_UPD_WAIT:  begin
                if (update_done)       state_d = S_IDLE;
                else if (wait_expired) state_d = S_IDLE;
            end
            default:     state_d = S_IDLE;
        endcase
    end

    // Pulse/enable outputs are registered from the next state so they line up with state.
    always_comb begin
        clr_x_d       = clr_x_q;
        clr_y_d       = clr_y_q;
        wait_d        = wait_q;
        frame_count_d = frame_count_q;
        timeout_err_d = timeout_err_q;
        overrun_d     = overrun_q | (frame_tick && (state_q != S_IDLE));
        case (state_q)
            S_IDLE: begin
                if (frame_tick) begin
                    clr_x_d = '0;
                    clr_y_d = '0;
                end
            end
            S_CLEAR: begin
                if (!clear_last) begin
                    if (clr_x_q == X_LAST) begin
                        clr_x_d = '0;
                        clr_y_d = clr_y_q + 7'd1;
                    end else begin
                        clr_x_d = clr_x_q + 8'd1;
                    end
                end
            end
            S_DRAW, S_UPDATE: wait_d = '0;
            S_DRAW_WAIT: begin
                if (!pass_done) begin
                    if (wait_expired) timeout_err_d = 1'b1;
                    else              wait_d = wait_q + 16'd1;
                end
            end
            S_UPD_WAIT: begin
                if (update_done)       frame_count_d = frame_count_q + 16'd1;
                else if (wait_expired) timeout_err_d = 1'b1;
                else                   wait_d = wait_q + 16'd1;
            end
            default: ;
        endcase
        clr_we_d    = (state_d == S_CLEAR);
        draw_go_d   = (state_d == S_DRAW);
        update_go_d = (state_d == S_UPDATE);
        busy_d      = (state_d != S_IDLE);
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            clr_x_q       <= '0;
            clr_y_q       <= '0;
            clr_we_q      <= 1'b0;
            draw_go_q     <= 1'b0;
            update_go_q   <= 1'b0;
            busy_q        <= 1'b0;
            frame_count_q <= '0;
            overrun_q     <= 1'b0;
            timeout_err_q <= 1'b0;
            wait_q        <= '0;
        end else begin
            clr_x_q       <= clr_x_d;
            clr_y_q       <= clr_y_d;
            clr_we_q      <= clr_we_d;
            draw_go_q     <= draw_go_d;
            update_go_q   <= update_go_d;
            busy_q        <= busy_d;
            frame_count_q <= frame_count_d;
            overrun_q     <= overrun_d;
            timeout_err_q <= timeout_err_d;
            wait_q        <= wait_d;
        end
    end

    assign clr_x       = clr_x_q;
    assign clr_y       = clr_y_q;
    assign clr_we      = clr_we_q;
    assign draw_go     = draw_go_q;
    assign update_go   = update_go_q;
    assign busy        = busy_q;
    assign state       = state_q;
    assign frame_count = frame_count_q;
    assign overrun     = overrun_q;
    assign timeout_err = timeout_err_q;

endmodule

// File: tb/tb_frame_sequencer.sv
// Bench for frame_sequencer: timeline model of a frame built from the block's rules,
// driven with directed and randomized handshake delays and stray frame ticks.
module tb_frame_sequencer;

    localparam int W  = 4;
    localparam int H  = 2;
    localparam int TO = 10;

    logic        clk = 1'b0;
    logic        reset_n = 1'b1;
    logic        frame_tick = 1'b0;
    logic        pass_done = 1'b0;
    logic        update_done = 1'b0;
    logic [7:0]  clr_x;
    logic [6:0]  clr_y;
    logic        clr_we;
    logic        draw_go;
    logic        update_go;
    logic        busy;
    logic [2:0]  state;
    logic [15:0] frame_count;
    logic        overrun;
    logic        timeout_err;

    int nvec = 0;
    int nerr = 0;

    logic [15:0] exp_fc  = 16'd0;
    logic        exp_ovr = 1'b0;
    logic        exp_to  = 1'b0;

    frame_sequencer #(.SCREEN_W(W), .SCREEN_H(H), .TIMEOUT(TO)) dut (
        .clk(clk), .reset_n(reset_n), .frame_tick(frame_tick), .pass_done(pass_done),
        .update_done(update_done), .clr_x(clr_x), .clr_y(clr_y), .clr_we(clr_we),
        .draw_go(draw_go), .update_go(update_go), .busy(busy), .state(state),
        .frame_count(frame_count), .overrun(overrun), .timeout_err(timeout_err)
    );

    always #5 clk = ~clk;

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        logic [40:0] got;
        reset_n = 1'b1;
        #2;
        reset_n = 1'b0;
        #2;
        got = {state, clr_x, clr_y, clr_we, draw_go, update_go, busy, frame_count, overrun, timeout_err};
        nvec++;
        if (got !== 41'd0) begin
            nerr++;
            $display("FAIL reset_state got %h exp %h", got, 41'd0);
        end
        cyc();
        cyc();
        reset_n = 1'b1;
        cyc();
        got = {state, clr_x, clr_y, clr_we, draw_go, update_go, busy, frame_count, overrun, timeout_err};
        nvec++;
        if (got !== 41'd0) begin
            nerr++;
            $display("FAIL reset_release got %h exp %h", got, 41'd0);
        end
        exp_fc = 16'd0; exp_ovr = 1'b0; exp_to = 1'b0;
    endtask

    // p / u: wait-state cycle in which the done pulse is given (> TO means never).
    // clr_tick_at: clear pixel index at which a stray frame_tick is raised (>= W*H: none).
    task automatic run_frame(input int p, input int u, input int clr_tick_at, input bit tick_at_upd);
        logic [22:0] got, exp;
        logic [17:0] gotf, expf;
        bit timed;
        frame_tick = 1'b1;
        cyc();
        frame_tick = 1'b0;
        for (int i = 0; i < W * H; i++) begin
            got = {state, clr_we, draw_go, update_go, busy, clr_x, clr_y};
            exp = {3'd1, 1'b1, 1'b0, 1'b0, 1'b1, 8'(i % W), 7'(i / W)};
            nvec++;
            if (got !== exp) begin
                nerr++;
                $display("FAIL clear_px%0d got %h exp %h", i, got, exp);
            end
            if (i == clr_tick_at) begin
                frame_tick = 1'b1;
                exp_ovr = 1'b1;
            end
            cyc();
            frame_tick = 1'b0;
        end
        got = {state, clr_we, draw_go, update_go, busy, clr_x, clr_y};
        exp = {3'd2, 1'b0, 1'b1, 1'b0, 1'b1, 8'(W - 1), 7'(H - 1)};
        nvec++;
        if (got !== exp) begin
            nerr++;
            $display("FAIL draw_go got %h exp %h", got, exp);
        end
        cyc();
        timed = 1'b1;
        for (int k = 0; k <= TO; k++) begin
            got = {state, clr_we, draw_go, update_go, busy, 15'd0};
            exp = {3'd3, 1'b0, 1'b0, 1'b0, 1'b1, 15'd0};
            nvec++;
            if (got !== exp) begin
                nerr++;
                $display("FAIL draw_wait%0d got %h exp %h", k, got, exp);
            end
            if (k == p) begin
                pass_done = 1'b1;
                cyc();
                pass_done = 1'b0;
                timed = 1'b0;
                break;
            end
            cyc();
        end
        if (timed) begin
            exp_to = 1'b1;
            for (int j = 0; j < 3; j++) begin
                gotf = {state, busy, update_go, frame_count[12:0]};
                expf = {3'd0, 1'b0, 1'b0, exp_fc[12:0]};
                nvec++;
                if (gotf !== expf || timeout_err !== 1'b1 || overrun !== exp_ovr) begin
                    nerr++;
                    $display("FAIL draw_timeout got %h/%b%b exp %h/%b%b", gotf, timeout_err, overrun, expf, 1'b1, exp_ovr);
                end
                cyc();
            end
            return;
        end
        got = {state, clr_we, draw_go, update_go, busy, 15'd0};
        exp = {3'd4, 1'b0, 1'b0, 1'b1, 1'b1, 15'd0};
        nvec++;
        if (got !== exp) begin
            nerr++;
            $display("FAIL update_go got %h exp %h", got, exp);
        end
        cyc();
        timed = 1'b1;
        for (int k = 0; k <= TO; k++) begin
            got = {state, clr_we, draw_go, update_go, busy, 15'd0};
            exp = {3'd5, 1'b0, 1'b0, 1'b0, 1'b1, 15'd0};
            nvec++;
            if (got !== exp) begin
                nerr++;
                $display("FAIL upd_wait%0d got %h exp %h", k, got, exp);
            end
            if (k == u) begin
                update_done = 1'b1;
                if (tick_at_upd) begin
                    frame_tick = 1'b1;
                    exp_ovr = 1'b1;
                end
                cyc();
                update_done = 1'b0;
                frame_tick = 1'b0;
                exp_fc = exp_fc + 16'd1;
                timed = 1'b0;
                break;
            end
            cyc();
        end
        if (timed) exp_to = 1'b1;
        gotf = {state, busy, update_go, frame_count[12:0]};
        expf = {3'd0, 1'b0, 1'b0, exp_fc[12:0]};
        nvec++;
        if (gotf !== expf || frame_count !== exp_fc || overrun !== exp_ovr || timeout_err !== exp_to) begin
            nerr++;
            $display("FAIL frame_end got st=%0d busy=%b fc=%0d ovr=%b to=%b exp st=0 busy=0 fc=%0d ovr=%b to=%b",
                     state, busy, frame_count, overrun, timeout_err, exp_fc, exp_ovr, exp_to);
        end
    endtask

    task automatic test_basic_frame();
        run_frame(5, 3, W * H, 1'b0);
        nvec++;
        if ({frame_count, busy, overrun, timeout_err} !== {16'd1, 3'b000}) begin
            nerr++;
            $display("FAIL basic_frame got fc=%0d busy=%b ovr=%b to=%b exp fc=1 busy=0 ovr=0 to=0",
                     frame_count, busy, overrun, timeout_err);
        end
    endtask

    task automatic test_overrun_in_clear();
        run_frame(2, 1, 3, 1'b0);
    endtask

    task automatic test_back_to_back();
        run_frame(0, 0, W * H, 1'b1);
        run_frame(1, 2, W * H, 1'b0);
    endtask

    task automatic test_timeout();
        run_frame(TO, TO, W * H, 1'b0);
        run_frame(TO + 1, 0, W * H, 1'b0);
        run_frame(0, TO + 1, W * H, 1'b0);
    endtask

    task automatic test_random();
        int p, u, ct;
        bit tk;
        for (int n = 0; n < 25; n++) begin
            p  = ($urandom_range(0, 5) == 0) ? TO + 1 : int'($urandom_range(0, TO));
            u  = ($urandom_range(0, 5) == 0) ? TO + 1 : int'($urandom_range(0, TO));
            ct = int'($urandom_range(0, 3 * W * H));
            tk = ($urandom_range(0, 3) == 0);
            run_frame(p, u, ct, tk);
            for (int g = int'($urandom_range(0, 2)); g > 0; g--) cyc();
        end
    endtask

    task automatic test_reset_mid_clear();
        logic [40:0] got;
        frame_tick = 1'b1;
        cyc();
        frame_tick = 1'b0;
        cyc();
        cyc();
        #3;
        reset_n = 1'b0;
        #1;
        got = {state, clr_x, clr_y, clr_we, draw_go, update_go, busy, frame_count, overrun, timeout_err};
        nvec++;
        if (got !== 41'd0) begin
            nerr++;
            $display("FAIL async_reset got %h exp %h", got, 41'd0);
        end
        exp_fc = 16'd0; exp_ovr = 1'b0; exp_to = 1'b0;
        cyc();
        reset_n = 1'b1;
        for (int j = 0; j < 20; j++) begin
            cyc();
            nvec++;
            if ({state, busy, draw_go, update_go, clr_we} !== 7'd0) begin
                nerr++;
                $display("FAIL post_reset_idle%0d got st=%0d busy=%b dg=%b ug=%b we=%b exp all 0",
                         j, state, busy, draw_go, update_go, clr_we);
            end
        end
        run_frame(4, 4, W * H, 1'b0);
    endtask

    initial begin
        test_reset();
        test_basic_frame();
        test_overrun_in_clear();
        test_back_to_back();
        test_timeout();
        test_random();
        test_reset_mid_clear();
        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

endmodule

// File: doc/frame_sequencer.md
FRAME_SEQUENCER -- requirements
Module: frame_sequencer

Interface
REQ-001 Parameter SCREEN_W, default 160, framebuffer width in pixels.
REQ-002 Parameter SCREEN_H, default 120, framebuffer height in pixels.
REQ-003 Parameter TIMEOUT, default 65535, maximum cycles allowed in a wait state.
REQ-004 Port clk  input  1  single clock; all state changes on its rising edge.
REQ-005 Port reset_n  input  1  asynchronous, active-low reset.
REQ-006 Port frame_tick  input  1  one-cycle pulse at start of vertical blank.
REQ-007 Port pass_done  input  1  one-cycle pulse from the entity draw pass when all entities are drawn.
REQ-008 Port update_done  input  1  one-cycle pulse from the game-state update logic when the update is complete.
REQ-009 Port clr_x  output  8  erase pixel x coordinate.
REQ-010 Port clr_y  output  7  erase pixel y coordinate.
REQ-011 Port clr_we  output  1  erase write enable; colour written is always black.
REQ-012 Port draw_go  output  1  one-cycle pulse that starts the entity draw pass.
REQ-013 Port update_go  output  1  one-cycle pulse that starts the game-state update.
REQ-014 Port busy  output  1  high whenever state is not S_IDLE.
REQ-015 Port state  output  3  current state encoding, for debug.
REQ-016 Port frame_count  output  16  number of completed frames.
REQ-017 Port overrun  output  1  sticky flag: a frame_tick arrived while busy.
REQ-018 Port timeout_err  output  1  sticky flag: a wait state exceeded TIMEOUT.

Function
REQ-019 States SHALL be encoded as S_IDLE=0, S_CLEAR=1, S_DRAW=2, S_DRAW_WAIT=3, S_UPDATE=4, S_UPD_WAIT=5; any other value SHALL go to S_IDLE on the next edge.
REQ-020 In S_IDLE, frame_tick=1 SHALL move the block to S_CLEAR on the next edge with clr_x=0 and clr_y=0.
REQ-021 In S_CLEAR, clr_we SHALL be 1 every cycle, writing one pixel per cycle.
REQ-022 In S_CLEAR, clr_x SHALL increment each cycle; at SCREEN_W-1 it SHALL wrap to 0 and clr_y SHALL increment.
REQ-023 The cycle that writes (SCREEN_W-1, SCREEN_H-1) SHALL be the last S_CLEAR cycle, so the clear takes exactly SCREEN_W*SCREEN_H cycles; the next state is S_DRAW.
REQ-024 clr_we SHALL be 0 in every state except S_CLEAR; clr_x and clr_y SHALL hold their last values outside S_CLEAR.
REQ-025 S_DRAW SHALL last one cycle with draw_go=1, then go to S_DRAW_WAIT.
REQ-026 pass_done SHALL be sampled only in S_DRAW_WAIT; pass_done=1 there SHALL move the block to S_UPDATE.
REQ-027 S_UPDATE SHALL last one cycle with update_go=1, then go to S_UPD_WAIT.
REQ-028 update_done SHALL be sampled only in S_UPD_WAIT; update_done=1 there SHALL move the block to S_IDLE and increment frame_count, wrapping from 0xFFFF to 0.
REQ-029 A 16-bit wait counter SHALL clear on entry to S_DRAW_WAIT and on entry to S_UPD_WAIT, and SHALL increment each cycle spent in either state.
REQ-030 If the wait counter reaches TIMEOUT and the done input is 0 in that cycle, the block SHALL go to S_IDLE, set timeout_err, and leave frame_count unchanged.
REQ-031 If the done input is 1 in the same cycle the counter reaches TIMEOUT, the done input SHALL take priority over the timeout.
REQ-032 frame_tick=1 in any non-IDLE state SHALL set overrun and SHALL otherwise be ignored; the tick is not queued.
REQ-033 If frame_tick and update_done are both 1 in S_UPD_WAIT, the block SHALL set overrun, go to S_IDLE and increment frame_count; the tick is dropped.
REQ-034 busy SHALL be 0 in the cycle after the transition to S_IDLE, so a frame_tick one cycle later SHALL be accepted.
REQ-035 draw_go, update_go and clr_we SHALL be registered outputs with no combinational path from any input.

Reset
REQ-036 Asserting reset_n=0 SHALL, asynchronously and independent of clk, force: state=S_IDLE; clr_x=0, clr_y=0, clr_we=0; draw_go=0, update_go=0; busy=0; frame_count=0; overrun=0; timeout_err=0; wait counter=0.
REQ-037 A reset asserted mid-clear or mid-wait SHALL abandon the frame with no further draw_go or update_go pulses.
REQ-038 Reset SHALL be the only way to clear the sticky flags overrun and timeout_err.

Verification
REQ-039 With SCREEN_W=4, SCREEN_H=2: one frame_tick -> exactly 8 consecutive cycles of clr_we=1 with (x,y) = (0,0),(1,0),(2,0),(3,0),(0,1)..(3,1) -> draw_go pulses on the next cycle.
REQ-040 Full frame with pass_done 5 cycles after draw_go and update_done 3 cycles after update_go -> frame_count=1, busy=0, both sticky flags 0.
REQ-041 frame_tick during S_CLEAR -> overrun=1, clear continues unaffected, only one draw_go issued.
REQ-042 With TIMEOUT=10 and pass_done never asserted -> S_IDLE about 10 cycles after draw_go, timeout_err=1, frame_count unchanged, no update_go issued.
REQ-043 update_done and frame_tick in the same cycle -> frame_count increments, overrun=1, block stays in S_IDLE.
REQ-044 reset_n=0 mid-S_CLEAR, asserted between clock edges -> all outputs at reset values immediately, before the next clk edge.
